// File: rtl/alu_share_pkg.sv
// Shared op codes, FSM encoding and operand/result records for the ALU sharing controller.
// Optional statistics are enabled by defining ALU_SHARE_STATS_EN.
package alu_share_pkg;

  localparam int ALU_W = 8;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_NOT = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_ASR = 3'd4;
  localparam logic [2:0] ALU_SHL = 3'd5;
  localparam logic [2:0] ALU_EQ  = 3'd6;
  localparam logic [2:0] ALU_NE  = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic [2:0]       sel;
    logic [ALU_W-1:0] a;
    logic [ALU_W-1:0] b;
  } alu_op_t;

  typedef struct packed {
    logic [ALU_W-1:0] f;
    logic             ovf;
    logic             branch;
  } alu_rsp_t;

endpackage

// File: rtl/alu_share_ctrl_if.sv
// Request/response bundle between NUM_REQ requesters (master) and the ALU sharing controller (slave).
interface alu_share_ctrl_if
  import alu_share_pkg::*;
#(
  parameter int NUM_REQ = 2
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [3*NUM_REQ-1:0]     req_sel;
  logic [ALU_W*NUM_REQ-1:0] req_a;
  logic [ALU_W*NUM_REQ-1:0] req_b;
  logic [NUM_REQ-1:0]       rsp_valid;
  logic [NUM_REQ-1:0]       rsp_ready;
  logic [ALU_W-1:0]         rsp_f;
  logic                     rsp_ovf;
  logic                     rsp_branch;
  logic                     busy;

  modport master (
    output req_valid, req_sel, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_f, rsp_ovf, rsp_branch, busy
  );

  modport slave (
    input  req_valid, req_sel, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_f, rsp_ovf, rsp_branch, busy
  );
endinterface

// File: rtl/alu_share_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above rr_ptr (with wrap) wins.
module rr_arbiter
  import alu_share_pkg::*;
#(
  parameter  int NUM_REQ = 2,
  localparam int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [PTR_W-1:0]   gnt_idx,
  output logic               gnt_any
);
  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    // scan farthest-first so the closest requester to rr_ptr is written last
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[(int'(rr_ptr) + k) % NUM_REQ]) begin
        gnt_idx = PTR_W'((int'(rr_ptr) + k) % NUM_REQ);
        gnt_any = 1'b1;
      end
    end
    gnt = gnt_any ? (NUM_REQ'(1) << gnt_idx) : '0;
  end
endmodule

// File: rtl/eightbit_alu.sv
// Combinational 8-bit signed ALU: arithmetic, logic, shifts and compare-for-branch.
module eightbit_alu
  import alu_share_pkg::*;
(
  input  logic signed [ALU_W-1:0] a,
  input  logic signed [ALU_W-1:0] b,
  input  logic        [2:0]       sel,
  output logic signed [ALU_W-1:0] f,
  output logic                    ovf,
  output logic                    take_branch
);
  always_comb begin
    f           = '0;
    ovf         = 1'b0;
    take_branch = 1'b0;
    case (sel)
      ALU_ADD: begin
        f   = a + b;
        // same-sign operands producing an opposite-sign sum
        ovf = (a[ALU_W-1] == b[ALU_W-1]) && (f[ALU_W-1] != a[ALU_W-1]);
      end
      ALU_NOT: f = ~b;
      ALU_AND: f = a & b;
      ALU_OR:  f = a | b;
      ALU_ASR: f = {a[ALU_W-1], a[ALU_W-1:1]};
      ALU_SHL: f = {a[ALU_W-2:0], 1'b0};
      ALU_EQ:  take_branch = (a == b);
      ALU_NE:  take_branch = (a != b);
      default: f = '0;
    endcase
  end
endmodule

// File: rtl/alu_share_ctrl.sv
// Round-robin sharing of one eightbit_alu among NUM_REQ requesters: accept, execute, respond.
// Define ALU_SHARE_STATS_EN to add saturating op/overflow counters.
module alu_share_ctrl
  import alu_share_pkg::*;
#(
  parameter  int NUM_REQ = 2,
  localparam int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic              clk,
  input  logic              reset,
  alu_share_ctrl_if.slave   bus
`ifdef ALU_SHARE_STATS_EN
  ,
  output logic [15:0]       stat_ops,
  output logic [7:0]        stat_ovf
`endif
);
  state_e             state_q,     state_d;
  logic [PTR_W-1:0]   rr_ptr_q,    rr_ptr_d;
  logic [PTR_W-1:0]   owner_q,     owner_d;
  alu_op_t            op_q,        op_d;
  alu_rsp_t           rsp_q,       rsp_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic               busy_q,      busy_d;

  logic [NUM_REQ-1:0] gnt;
  logic [PTR_W-1:0]   gnt_idx;
  logic               gnt_any;
  logic [ALU_W-1:0]   alu_f;
  logic               alu_ovf;
  logic               alu_br;
  logic               rsp_hs;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req     (bus.req_valid),
    .rr_ptr  (rr_ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  // the ALU only ever sees the latched operands
  eightbit_alu u_alu (
    .a           (op_q.a),
    .b           (op_q.b),
    .sel         (op_q.sel),
    .f           (alu_f),
    .ovf         (alu_ovf),
    .take_branch (alu_br)
  );

  assign rsp_hs = (state_q == RESP) && bus.rsp_ready[owner_q];

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    op_d        = op_q;
    rsp_d       = rsp_q;
    rsp_valid_d = rsp_valid_q;
    busy_d      = busy_q;
    case (state_q)
      IDLE: begin
        if (gnt_any) begin
          owner_d  = gnt_idx;
          op_d.sel = bus.req_sel[3*int'(gnt_idx) +: 3];
          op_d.a   = bus.req_a[ALU_W*int'(gnt_idx) +: ALU_W];
          op_d.b   = bus.req_b[ALU_W*int'(gnt_idx) +: ALU_W];
          busy_d   = 1'b1;
          state_d  = EXEC;
        end
      end
      EXEC: begin
        rsp_d.f      = alu_f;
        rsp_d.ovf    = alu_ovf;
        rsp_d.branch = alu_br;
        rsp_valid_d  = NUM_REQ'(1) << owner_q;
        state_d      = RESP;
      end
      RESP: begin
        if (rsp_hs) begin
          rsp_valid_d = '0;
          busy_d      = 1'b0;
          rr_ptr_d    = (int'(owner_q) == NUM_REQ - 1) ? '0 : owner_q + PTR_W'(1);
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef ALU_SHARE_STATS_EN
  logic [15:0] stat_ops_q, stat_ops_d;
  logic [7:0]  stat_ovf_q, stat_ovf_d;

  always_comb begin
    stat_ops_d = stat_ops_q;
    stat_ovf_d = stat_ovf_q;
    if (rsp_hs && stat_ops_q != 16'hFFFF) stat_ops_d = stat_ops_q + 16'd1;
    if (rsp_hs && rsp_q.ovf && stat_ovf_q != 8'hFF) stat_ovf_d = stat_ovf_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_ops_q <= '0;
      stat_ovf_q <= '0;
    end else begin
      stat_ops_q <= stat_ops_d;
      stat_ovf_q <= stat_ovf_d;
    end
  end

  assign stat_ops = stat_ops_q;
  assign stat_ovf = stat_ovf_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      op_q        <= '0;
      rsp_q       <= '0;
      rsp_valid_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      op_q        <= op_d;
      rsp_q       <= rsp_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
    end
  end

  // accept is combinational so a waiting requester transfers in its first IDLE cycle
  assign bus.req_ready  = (state_q == IDLE) ? gnt : '0;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_f      = rsp_q.f;
  assign bus.rsp_ovf    = rsp_q.ovf;
  assign bus.rsp_branch = rsp_q.branch;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed self-checking bench for alu_share_ctrl with two requesters.
module tb_alu_share_ctrl;
  localparam int NUM_REQ = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  alu_share_ctrl_if #(.NUM_REQ(NUM_REQ)) bus ();

`ifdef ALU_SHARE_STATS_EN
  logic [15:0] stat_ops;
  logic [7:0]  stat_ovf;
`endif

  alu_share_ctrl #(.NUM_REQ(NUM_REQ)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef ALU_SHARE_STATS_EN
    ,
    .stat_ops (stat_ops),
    .stat_ovf (stat_ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req_valid = '0;
    bus.req_sel   = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = '0;
  endtask

  task automatic set_req(input int i, input logic [2:0] sel, input logic [7:0] a, input logic [7:0] b);
    bus.req_valid[i]     = 1'b1;
    bus.req_sel[3*i +: 3] = sel;
    bus.req_a[8*i +: 8]   = a;
    bus.req_b[8*i +: 8]   = b;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    n_cmp++; if (bus.req_ready !== 2'b00) begin n_bad++; $display("FAIL reset_req_ready got %b exp 00", bus.req_ready); end
    n_cmp++; if (bus.rsp_valid !== 2'b00) begin n_bad++; $display("FAIL reset_rsp_valid got %b exp 00", bus.rsp_valid); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
    n_cmp++; if ({bus.rsp_f, bus.rsp_ovf, bus.rsp_branch} !== 10'h000)
      begin n_bad++; $display("FAIL reset_rsp got f=%h ovf=%b br=%b exp 00/0/0", bus.rsp_f, bus.rsp_ovf, bus.rsp_branch); end
    reset = 1'b0;
  endtask

  task automatic test_add_ovf();
    set_req(0, 3'd0, 8'h7F, 8'h01);
    #1;
    n_cmp++; if (bus.req_ready !== 2'b01) begin n_bad++; $display("FAIL add_req_ready got %b exp 01", bus.req_ready); end
    tick();
    bus.req_valid = '0;
    #1;
    n_cmp++; if ({bus.busy, bus.rsp_valid, bus.req_ready} !== 5'b1_00_00)
      begin n_bad++; $display("FAIL add_exec got busy=%b rsp_valid=%b req_ready=%b exp 1/00/00", bus.busy, bus.rsp_valid, bus.req_ready); end
    tick();
    n_cmp++; if (bus.rsp_valid !== 2'b01) begin n_bad++; $display("FAIL add_rsp_valid got %b exp 01", bus.rsp_valid); end
    n_cmp++; if ({bus.rsp_f, bus.rsp_ovf, bus.rsp_branch} !== {8'h80, 1'b1, 1'b0})
      begin n_bad++; $display("FAIL add_rsp got f=%h ovf=%b br=%b exp 80/1/0", bus.rsp_f, bus.rsp_ovf, bus.rsp_branch); end
    bus.rsp_ready = 2'b01;
    tick();
    bus.rsp_ready = 2'b00;
    n_cmp++; if ({bus.busy, bus.rsp_valid} !== 3'b0_00)
      begin n_bad++; $display("FAIL add_done got busy=%b rsp_valid=%b exp 0/00", bus.busy, bus.rsp_valid); end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_g;
    logic [7:0] exp_f;
    logic       exp_br;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    set_req(0, 3'd0, 8'h03, 8'h04);
    set_req(1, 3'd6, 8'h55, 8'h55);
    bus.rsp_ready = 2'b11;
    #1;
    for (int op = 0; op < 4; op++) begin
      exp_g  = 2'b01 << (op % 2);
      exp_f  = (op % 2 == 0) ? 8'h07 : 8'h00;
      exp_br = (op % 2 == 1);
      n_cmp++; if (bus.req_ready !== exp_g) begin n_bad++; $display("FAIL rr_grant%0d got %b exp %b", op, bus.req_ready, exp_g); end
      tick();
      tick();
      n_cmp++; if ({bus.rsp_valid, bus.rsp_f, bus.rsp_branch} !== {exp_g, exp_f, exp_br})
        begin n_bad++; $display("FAIL rr_rsp%0d got v=%b f=%h br=%b exp %b/%h/%b", op, bus.rsp_valid, bus.rsp_f, bus.rsp_branch, exp_g, exp_f, exp_br); end
      tick();
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_backpressure();
    set_req(1, 3'd3, 8'h0F, 8'hF0);
    #1;
    n_cmp++; if (bus.req_ready !== 2'b10) begin n_bad++; $display("FAIL bp_req_ready got %b exp 10", bus.req_ready); end
    tick();
    bus.req_valid[1] = 1'b0;
    set_req(0, 3'd2, 8'hAA, 8'h55);
    tick();
    bus.rsp_ready = 2'b01;
    for (int c = 0; c < 5; c++) begin
      n_cmp++; if ({bus.rsp_valid, bus.rsp_f, bus.req_ready, bus.busy} !== {2'b10, 8'hFF, 2'b00, 1'b1})
        begin n_bad++; $display("FAIL bp_hold%0d got v=%b f=%h rdy=%b busy=%b exp 10/ff/00/1", c, bus.rsp_valid, bus.rsp_f, bus.req_ready, bus.busy); end
      tick();
    end
    bus.rsp_ready = 2'b10;
    tick();
    bus.rsp_ready = 2'b00;
    n_cmp++; if ({bus.rsp_valid, bus.req_ready} !== 4'b00_01)
      begin n_bad++; $display("FAIL bp_release got v=%b rdy=%b exp 00/01", bus.rsp_valid, bus.req_ready); end
    idle_inputs();
    tick();
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL bp_drop_busy got %b exp 0", bus.busy); end
  endtask

  task automatic test_ops();
    logic [33:0] vec [8];
    logic [2:0]  sel;
    logic [7:0]  a, b, ef;
    logic        eo, eb;
    vec[0] = {3'd4, 8'h80, 8'h00, 8'hC0, 1'b0, 1'b0};
    vec[1] = {3'd5, 8'hFF, 8'h00, 8'hFE, 1'b0, 1'b0};
    vec[2] = {3'd1, 8'h00, 8'h0F, 8'hF0, 1'b0, 1'b0};
    vec[3] = {3'd2, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0};
    vec[4] = {3'd0, 8'h80, 8'hFF, 8'h7F, 1'b1, 1'b0};
    vec[5] = {3'd7, 8'h01, 8'h02, 8'h00, 1'b0, 1'b1};
    vec[6] = {3'd6, 8'h01, 8'h02, 8'h00, 1'b0, 1'b0};
    vec[7] = {3'd5, 8'h40, 8'h00, 8'h80, 1'b0, 1'b0};
    for (int v = 0; v < 8; v++) begin
      {sel, a, b, ef, eo, eb} = vec[v];
      set_req(0, sel, a, b);
      tick();
      bus.req_valid = '0;
      tick();
      n_cmp++; if ({bus.rsp_valid, bus.rsp_f, bus.rsp_ovf, bus.rsp_branch} !== {2'b01, ef, eo, eb})
        begin n_bad++; $display("FAIL op%0d_sel%0d got v=%b f=%h ovf=%b br=%b exp 01/%h/%b/%b", v, sel, bus.rsp_valid, bus.rsp_f, bus.rsp_ovf, bus.rsp_branch, ef, eo, eb); end
      bus.rsp_ready = 2'b01;
      tick();
      bus.rsp_ready = 2'b00;
    end
  endtask

  task automatic test_reset_mid();
    set_req(0, 3'd0, 8'h01, 8'h01);
    tick();
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_cmp++; if ({bus.busy, bus.rsp_valid} !== 3'b0_00)
      begin n_bad++; $display("FAIL rstmid_state got busy=%b v=%b exp 0/00", bus.busy, bus.rsp_valid); end
    tick();
    n_cmp++; if (bus.rsp_valid !== 2'b00) begin n_bad++; $display("FAIL rstmid_no_rsp got %b exp 00", bus.rsp_valid); end
    set_req(0, 3'd0, 8'h01, 8'h01);
    set_req(1, 3'd0, 8'h02, 8'h02);
    #1;
    n_cmp++; if (bus.req_ready !== 2'b01) begin n_bad++; $display("FAIL rstmid_ptr0 got %b exp 01", bus.req_ready); end
    bus.req_valid[0] = 1'b0;
    #1;
    n_cmp++; if (bus.req_ready !== 2'b10) begin n_bad++; $display("FAIL rstmid_req1_alone got %b exp 10", bus.req_ready); end
    idle_inputs();
    tick();
  endtask

`ifdef ALU_SHARE_STATS_EN
  task automatic test_stats();
    logic [7:0] av [3];
    av[0] = 8'h7F; av[1] = 8'h01; av[2] = 8'h10;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_cmp++; if ({stat_ops, stat_ovf} !== 24'h0) begin n_bad++; $display("FAIL stats_reset got %h/%h exp 0/0", stat_ops, stat_ovf); end
    for (int k = 0; k < 3; k++) begin
      set_req(0, 3'd0, av[k], 8'h01);
      tick();
      bus.req_valid = '0;
      tick();
      bus.rsp_ready = 2'b01;
      tick();
      bus.rsp_ready = 2'b00;
    end
    n_cmp++; if ({stat_ops, stat_ovf} !== {16'd3, 8'd1})
      begin n_bad++; $display("FAIL stats_count got ops=%0d ovf=%0d exp 3/1", stat_ops, stat_ovf); end
  endtask
`endif

  initial begin
    idle_inputs();
    test_reset();
    test_add_ovf();
    test_round_robin();
    test_backpressure();
    test_ops();
    test_reset_mid();
`ifdef ALU_SHARE_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
